// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//
// Receives the PS/2 keyboard device-to-host stream and turns it into key
// events. Both pins are synchronized, and the PS/2 clock is glitch-filtered.
// Each 11-bit frame (start, 8 data LSB-first, odd parity, stop) is
// deserialized and checked. The E0 (extended) and F0 (break) prefixes are
// folded into flags that travel with the next real scan code.
//
// Ports
//   fclk         in   system clock (only clock in the block)
//   rst          in   synchronous reset, active-high
//   clkin        in   raw PS/2 clock pin (asynchronous)
//   datain       in   raw PS/2 data pin (asynchronous)
//   keycode      out  last delivered scan code, held until the next delivery
//   key_valid    out  1-cycle strobe, keycode/key_release/key_extended are new
//   key_release  out  delivered code was preceded by F0
//   key_extended out  delivered code was preceded by E0
//   frame_error  out  1-cycle strobe on parity, stop or timeout error
//
// Frame FSM
//   state    | meaning
//   S_IDLE   | waiting for a start bit (sample 0); a 1 is ignored
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the parity bit
//   S_STOP   | checking stop bit and parity, then back to idle

module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       clkin,
  input  logic       datain,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_error
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic           clk_s1, clk_s2;
  logic           dat_s1, dat_s2;
  logic           clk_f, clk_f_d;
  logic [FCW-1:0] flt_cnt;
  logic           fall;

  state_t         state, state_next;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           par_bit;
  logic [WDW-1:0] wd_cnt;
  logic           ext_pend, rel_pend;

  logic           timeout;
  logic           frame_ok;
  logic           frame_bad;

  // Two-flop synchronizers. Idle level of both PS/2 lines is high.
  always_ff @(posedge fclk) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= clkin;
      clk_s2 <= clk_s1;
      dat_s1 <= datain;
      dat_s2 <= dat_s1;
    end
  end

  // Clock glitch filter: clk_f follows clk_s2 only after FILTER_LEN
  // consecutive samples that differ from the current filtered level.
  always_ff @(posedge fclk) begin
    if (rst) begin
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FCW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FCW'(1);
      end
    end
  end

  assign fall = clk_f_d & ~clk_f;

  // Next-state logic. A falling edge takes priority over the watchdog, so an
  // edge landing on the timeout cycle keeps the frame alive.
  always_comb begin
    state_next = state;
    timeout    = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE:   if (!dat_s2) state_next = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP: begin
          state_next = S_IDLE;
          if (((^shift) ^ par_bit) && dat_s2) frame_ok  = 1'b1;
          else                                frame_bad = 1'b1;
        end
        default:  state_next = S_IDLE;
      endcase
    end else if (state != S_IDLE && wd_cnt == WDW'(TIMEOUT_CYCLES)) begin
      timeout    = 1'b1;
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Frame datapath
  always_ff @(posedge fclk) begin
    if (rst) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else if (fall) begin
      case (state)
        S_IDLE: bit_cnt <= '0;
        S_DATA: begin
          shift   <= {dat_s2, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_PARITY: par_bit <= dat_s2;
        default: ;
      endcase
    end
  end

  // Watchdog: counts fclk cycles between edges while a frame is open.
  always_ff @(posedge fclk) begin
    if (rst)                           wd_cnt <= '0;
    else if (fall || state == S_IDLE)  wd_cnt <= '0;
    else if (timeout)                  wd_cnt <= '0;
    else                               wd_cnt <= wd_cnt + WDW'(1);
  end

  // Prefix folding and registered outputs
  always_ff @(posedge fclk) begin
    if (rst) begin
      ext_pend     <= 1'b0;
      rel_pend     <= 1'b0;
      keycode      <= 8'h00;
      key_valid    <= 1'b0;
      key_release  <= 1'b0;
      key_extended <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      frame_error <= frame_bad | timeout;
      if (frame_bad || timeout) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end else if (frame_ok) begin
        if (shift == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shift == 8'hF0) begin
          rel_pend <= 1'b1;
        end else begin
          keycode      <= shift;
          key_extended <= ext_pend;
          key_release  <= rel_pend;
          key_valid    <= 1'b1;
          ext_pend     <= 1'b0;
          rel_pend     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: drives PS/2 frames on the pins, keeps a queue of
// expected key events / frame errors from a small prefix model, and a monitor
// pops and compares them whenever the DUT strobes.

module tb_ps2_scancode_rx;

  localparam int FL   = 4;
  localparam int TO   = 300;
  localparam int HALF = 20;

  logic       fclk = 1'b0;
  logic       rst  = 1'b1;
  logic       clkin = 1'b1;
  logic       datain = 1'b1;
  logic [7:0] keycode;
  logic       key_valid, key_release, key_extended, frame_error;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   err_cyc = 0;
  int   last_fall_cyc = 0;
  int   strobe_n = 0;
  bit   ext_m = 1'b0;
  bit   rel_m = 1'b0;
  logic [9:0] prev_hold = '0;
  logic [11:0] obs_v, exp_v;

  ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .fclk(fclk), .rst(rst), .clkin(clkin), .datain(datain),
    .keycode(keycode), .key_valid(key_valid), .key_release(key_release),
    .key_extended(key_extended), .frame_error(frame_error)
  );

  always #5 fclk = ~fclk;
  always @(posedge fclk) cyc++;

  // Scoreboard monitor
  always @(negedge fclk) begin
    if (!rst) begin
      if (key_valid === 1'b1 || frame_error === 1'b1) begin
        checks++;
        strobe_n++;
        obs_v = {key_valid, frame_error, keycode, key_release, key_extended};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe_%0d: got valid=%0b err=%0b code=%02h, required no strobe",
                   strobe_n, key_valid, frame_error, keycode);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.is_err) begin
            exp_v   = {2'b01, prev_hold};
            err_cyc = cyc;
          end else begin
            exp_v = {2'b10, mon_e.code, mon_e.rel, mon_e.ext};
          end
          if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL strobe_%0d: got valid=%0b err=%0b code=%02h rel=%0b ext=%0b, required valid=%0b err=%0b code=%02h rel=%0b ext=%0b",
                     strobe_n, obs_v[11], obs_v[10], obs_v[9:2], obs_v[1], obs_v[0],
                     exp_v[11], exp_v[10], exp_v[9:2], exp_v[1], exp_v[0]);
          end
        end
      end else begin
        checks++;
        if ({keycode, key_release, key_extended} !== prev_hold) begin
          errors++;
          $display("FAIL hold: outputs changed without key_valid, got code=%02h rel=%0b ext=%0b, required %02h %0b %0b",
                   keycode, key_release, key_extended, prev_hold[9:2], prev_hold[1], prev_hold[0]);
        end
      end
    end
    prev_hold = {keycode, key_release, key_extended};
  end

  task automatic send_bit(input logic b);
    @(negedge fclk);
    datain = b;
    repeat (HALF) @(negedge fclk);
    clkin = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge fclk);
    clkin = 1'b1;
  endtask

  task automatic glitch_pulse();
    repeat (5) @(negedge fclk);
    clkin = 1'b0;
    repeat (FL - 1) @(negedge fclk);
    clkin = 1'b1;
  endtask

  // Full frame; model decides what the DUT should report.
  task automatic send_frame(input logic [7:0] d, input bit par_flip,
                            input logic stop, input bit glitch);
    logic par;
    ev_t  e;
    par = ~(^d) ^ par_flip;
    if (par_flip || !stop) begin
      e.is_err = 1'b1; e.code = 8'h00; e.rel = 1'b0; e.ext = 1'b0;
      exp_q.push_back(e);
      ext_m = 1'b0; rel_m = 1'b0;
    end else if (d == 8'hE0) begin
      ext_m = 1'b1;
    end else if (d == 8'hF0) begin
      rel_m = 1'b1;
    end else begin
      e.is_err = 1'b0; e.code = d; e.rel = rel_m; e.ext = ext_m;
      exp_q.push_back(e);
      ext_m = 1'b0; rel_m = 1'b0;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (glitch && i == 3) glitch_pulse();
    end
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge fclk);
      n++;
    end
    repeat (10) @(negedge fclk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge fclk);
    checks++; if (keycode !== 8'h00)     begin errors++; $display("FAIL reset_keycode: got %02h, required 00", keycode); end
    checks++; if (key_valid !== 1'b0)    begin errors++; $display("FAIL reset_key_valid: got %0b, required 0", key_valid); end
    checks++; if (key_release !== 1'b0)  begin errors++; $display("FAIL reset_key_release: got %0b, required 0", key_release); end
    checks++; if (key_extended !== 1'b0) begin errors++; $display("FAIL reset_key_extended: got %0b, required 0", key_extended); end
    checks++; if (frame_error !== 1'b0)  begin errors++; $display("FAIL reset_frame_error: got %0b, required 0", frame_error); end
    rst = 1'b0;
    repeat (20) @(negedge fclk);
  endtask

  task automatic test_make();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL make_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL break_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_ext_break();
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ext_break_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_bad_frames();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bad_frames_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_glitch_timeout();
    ev_t e;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
    // start bit + 4 data bits, then silence
    e.is_err = 1'b1; e.code = 8'h00; e.rel = 1'b0; e.ext = 1'b0;
    exp_q.push_back(e);
    ext_m = 1'b0; rel_m = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    wait_drain(TO + 100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
    // 2 sync + FL filter cycles to the edge, 1 cycle edge detect, TO+1 watchdog
    checks++;
    if (err_cyc - last_fall_cyc != TO + FL + 4) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles from pin fall, required %0d", err_cyc - last_fall_cyc, TO + FL + 4);
    end
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL after_timeout_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_mid_reset();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge fclk);
    rst = 1'b1;
    repeat (3) @(negedge fclk);
    checks++; if (keycode !== 8'h00)     begin errors++; $display("FAIL midreset_keycode: got %02h, required 00", keycode); end
    checks++; if ({key_valid, frame_error, key_release, key_extended} !== 4'b0000) begin
      errors++; $display("FAIL midreset_flags: got %04b, required 0000", {key_valid, frame_error, key_release, key_extended});
    end
    rst = 1'b0;
    ext_m = 1'b0; rel_m = 1'b0;
    repeat (TO + 50) @(negedge fclk);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h74, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d events outstanding, required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_bad_frames();
    test_glitch_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
